fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the sequential Y86-64 processor, directly upstream of PC update. Given a PC, it reads the instruction byte-serially from a byte-wide instruction memory over a req/ack handshake. It determines the instruction length from the opcode byte and splits the bytes into icode, ifun, rA, rB and valC. It computes valP, the fall-through PC that PC update selects for every non-control-flow instruction.

## Interface
Parameters:
- IMEM_TIMEOUT, default 16: cycles without ack after which the current byte read is abandoned with an error; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to fetch at pc_in; ignored while busy=1.
- pc_in  in  64  PC of the instruction to fetch; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse; all result outputs are valid from this cycle on.
- icode  out  4  opcode, byte0[7:4].
- ifun  out  4  function code, byte0[3:0].
- rA  out  4  byte1[7:4] if the instruction has a register byte, else 4'hF.
- rB  out  4  byte1[3:0] if the instruction has a register byte, else 4'hF.
- valC  out  64  little-endian constant, else 0.
- valP  out  64  PC + instruction length, with 64-bit wrap.
- instr_valid  out  1  0 when icode > 4'hB.
- imem_error  out  1  1 on imem_err or timeout.
- imem_req  out  1  byte read request.
- imem_addr  out  64  byte address, pc + idx with 64-bit wrap.
- imem_ack  in  1  read complete; imem_rdata and imem_err are valid in this cycle.
- imem_rdata  in  8  read byte.
- imem_err  in  1  access fault qualifier for imem_ack.

## Operation
Instruction lengths in bytes, by icode:
- 0 and 1: 1.
- 2: 2.
- 3, 4 and 5: 10.
- 6: 2.
- 7 and 8: 9.
- 9: 1.
- A and B: 2.
- Invalid icode (> 4'hB): treated as length 1.

Register byte and valC placement:
- Register byte present for icodes 2, 3, 4, 5, 6, A and B.
- valC is bytes 2..9 for icodes 3, 4 and 5.
- valC is bytes 1..8 for icodes 7 and 8.
- valC is 0 for all other icodes.

FSM states: IDLE, FETCH, DONE.
- IDLE: busy=0 and imem_req=0. On start, latch pc_in, clear idx, the byte buffer and the error flags, then go to FETCH.
- FETCH: imem_req=1 and imem_addr=pc+idx. Each cycle with imem_ack=1:
  - If imem_err=1: set imem_error and go to DONE.
  - Otherwise store imem_rdata in byte[idx]. For idx=0, also decode the length; an invalid icode clears instr_valid. If idx+1 equals the length, go to DONE; otherwise increment idx.
- FETCH wait counter: increments each cycle without ack and clears on every ack. When it reaches IMEM_TIMEOUT, set imem_error and go to DONE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.

Output values:
- Result outputs are registered. They update only on the transition into DONE and hold until the next accepted start.
- On imem_error: icode, ifun and valC are 0, rA and rB are F, valP equals pc, instr_valid=0.
- valP = pc + length is computed in 64 bits; carry out is discarded.

Reset, asynchronous on rst_n low:
- state=IDLE, idx=0, wait counter=0.
- busy=0, done=0, imem_req=0, imem_addr=0.
- icode=0, ifun=0, rA=F, rB=F, valC=0, valP=0, instr_valid=0, imem_error=0.
- Reset mid-fetch abandons the read. An imem_ack arriving after reset, while in IDLE, is ignored.

## Timing
- start is sampled at edge E0. FETCH, with imem_req high, begins in the cycle after E0.
- With ack in the same cycle as req, one byte is captured per cycle. done is asserted len+1 cycles after E0: 2 for halt, 11 for irmovq.
- Each cycle of ack delay adds one cycle of latency.
- imem_addr advances in the cycle after an ack. imem_req stays high continuously through multi-byte fetches.
- A timeout raises done IMEM_TIMEOUT+1 cycles after the last ack, or after FETCH entry if no byte has been acked yet.
- start asserted while busy=1, including in the DONE cycle, is dropped. A start in the cycle after DONE, with state IDLE, is accepted.
- imem_ack while imem_req=0 is ignored.

## Test plan
- irmovq at PC 0x100: bytes 30 F3 EF CD AB 89 67 45 23 01, zero-wait ack.
  - Expect icode=3, ifun=0, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=0x10A.
  - Expect done 11 cycles after start and addresses 0x100..0x109 in order.
- jXX at PC 0x40: bytes 74 00 02 00 00 00 00 00 00, ack delayed 3 cycles per byte.
  - Expect icode=7, ifun=4, valC=0x200, valP=0x49, rA=F, rB=F.
  - Expect 9 reads and done 37 cycles after start.
- ret (0x90), halt (0x00) and invalid 0xC5:
  - ret: 1 read, valP=pc+1.
  - halt: 1 read, valP=pc+1.
  - 0xC5: 1 read, instr_valid=0, valP=pc+1.
- rmmovq with imem_err on byte 4: done on that ack; imem_error=1, valP=pc, no further reads.
- IMEM_TIMEOUT=4 with memory that never acks the 2nd byte of OPq 0x60:
  - Expect done 5 cycles after the byte-0 ack and imem_error=1.
- Reset mid-fetch and PC wrap:
  - rst_n low during the 5th byte of mrmovq: all outputs at reset values immediately, a late ack is ignored, and a fresh start fetches normally.
  - PC 0xFFFFFFFFFFFFFFFF with pushq A0 2F: 2nd address is 0, valP=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Y86-64 instruction fetch: reads one instruction byte-serially over a req/ack
// memory port, then splits it into icode/ifun/rA/rB/valC and computes valP.
module fetch_unit #(
  parameter int IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [7:0] WAIT_LIMIT = 8'(IMEM_TIMEOUT - 1);

  logic [1:0]  state_reg;
  logic [63:0] pc_reg;
  logic [3:0]  idx_reg;
  logic [3:0]  len_reg;
  logic [7:0]  wait_reg;
  logic [7:0]  byte_reg [10];
  logic [7:0]  byte_cur [10];

  logic        in_fetch, ack_ok, ack_bad, timeout_hit, last_byte, finish_err;
  logic [3:0]  len_cur;
  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      4'h7, 4'h8:             len_of = 4'd9;
      default:                len_of = 4'd1;
    endcase
  endfunction

  assign in_fetch    = (state_reg == FETCH);
  assign ack_ok      = in_fetch && imem_ack && !imem_err;
  assign ack_bad     = in_fetch && imem_ack && imem_err;
  assign timeout_hit = in_fetch && !imem_ack && (wait_reg == WAIT_LIMIT);
  assign finish_err  = ack_bad || timeout_hit;
  assign len_cur     = (idx_reg == 4'd0) ? len_of(imem_rdata[7:4]) : len_reg;
  assign last_byte   = ack_ok && ((idx_reg + 4'd1) == len_cur);

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign imem_req  = in_fetch;
  assign imem_addr = in_fetch ? pc_reg + {60'd0, idx_reg} : 64'd0;

  // View of the buffer with the byte arriving this cycle already merged in,
  // so the final byte can be decoded on the same edge that enters DONE.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_cur
      assign byte_cur[gi] = (idx_reg == 4'(gi)) ? imem_rdata : byte_reg[gi];
    end
  endgenerate

  always_comb begin
    d_icode = byte_cur[0][7:4];
    d_ifun  = byte_cur[0][3:0];
    d_ra    = 4'hF;
    d_rb    = 4'hF;
    d_valc  = 64'd0;
    case (d_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        d_ra = byte_cur[1][7:4];
        d_rb = byte_cur[1][3:0];
      end
      4'h3, 4'h4, 4'h5: begin
        d_ra   = byte_cur[1][7:4];
        d_rb   = byte_cur[1][3:0];
        d_valc = {byte_cur[9], byte_cur[8], byte_cur[7], byte_cur[6],
                  byte_cur[5], byte_cur[4], byte_cur[3], byte_cur[2]};
      end
      4'h7, 4'h8: begin
        d_valc = {byte_cur[8], byte_cur[7], byte_cur[6], byte_cur[5],
                  byte_cur[4], byte_cur[3], byte_cur[2], byte_cur[1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) byte_reg[i] <= 8'd0;
    end else if (state_reg == IDLE && start) begin
      for (int i = 0; i < 10; i++) byte_reg[i] <= 8'd0;
    end else if (ack_ok) begin
      byte_reg[idx_reg] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= 64'd0;
      idx_reg     <= 4'd0;
      len_reg     <= 4'd0;
      wait_reg    <= 8'd0;
      icode       <= 4'd0;
      ifun        <= 4'd0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= 64'd0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            pc_reg    <= pc_in;
            idx_reg   <= 4'd0;
            wait_reg  <= 8'd0;
          end
        end
        FETCH: begin
          wait_reg <= imem_ack ? 8'd0 : wait_reg + 8'd1;
          if (ack_ok && idx_reg == 4'd0) len_reg <= len_cur;
          if (finish_err || last_byte) state_reg <= DONE;
          else if (ack_ok)             idx_reg   <= idx_reg + 4'd1;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // Results change only on entry to DONE and hold until the next fetch ends.
      if (finish_err) begin
        icode       <= 4'd0;
        ifun        <= 4'd0;
        rA          <= 4'hF;
        rB          <= 4'hF;
        valC        <= 64'd0;
        valP        <= pc_reg;
        instr_valid <= 1'b0;
        imem_error  <= 1'b1;
      end else if (last_byte) begin
        icode       <= d_icode;
        ifun        <= d_ifun;
        rA          <= d_ra;
        rB          <= d_rb;
        valC        <= d_valc;
        valP        <= pc_reg + {60'd0, len_cur};
        instr_valid <= (d_icode <= 4'hB);
        imem_error  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: a behavioural memory responder
// plus an instruction-level reference model built from the length/layout rules.
module tb_fetch_unit;
  localparam int T = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [63:0] pc_in = 64'd0;
  logic        busy, done, instr_valid, imem_error, imem_req;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, imem_addr;
  logic        imem_ack = 1'b0, imem_err = 1'b0;
  logic [7:0]  imem_rdata = 8'd0;

  fetch_unit #(.IMEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
    .busy(busy), .done(done), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, txn = 0;
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  logic [7:0]  prog [16];
  logic [63:0] base = 64'd0, off;
  int          err_idx = 99, noack_idx = 99, del_mode = 0;
  int          req_cycles = 0, last_ack_at = 0, wait_cnt = 0, cur_delay = 0;
  logic        force_ack = 1'b0;
  logic [63:0] acks [$];

  logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
  logic [63:0] e_valc, e_valp;
  logic        e_valid, e_err, e_timeout;
  int          e_reads;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick_delay();
    return (del_mode < 0) ? int'($urandom_range(0, 3)) : del_mode;
  endfunction

  // Memory: acks after a per-byte delay, can fault or go silent on one byte.
  always @(negedge clk) begin
    if (imem_req) begin
      req_cycles++;
      off = imem_addr - base;
      if (off < 64'd16 && int'(off) != noack_idx && wait_cnt >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = prog[int'(off)];
        imem_err   = (int'(off) == err_idx);
        acks.push_back(imem_addr);
        last_ack_at = req_cycles;
        wait_cnt    = 0;
        cur_delay   = pick_delay();
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack   = force_ack;
      imem_rdata = 8'h30;
      imem_err   = 1'b0;
      wait_cnt   = 0;
      cur_delay  = pick_delay();
    end
  end

  task automatic load_bytes(input logic [79:0] v);
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) prog[i] = v[79 - 8*i -: 8];
  endtask

  task automatic model(input logic [63:0] pc);
    logic [3:0] ic;
    int len, vo;
    ic = prog[0][7:4];
    len = len_tab[ic];
    e_err = 1'b0; e_timeout = 1'b0; e_reads = len;
    if (err_idx < len) begin
      e_err = 1'b1; e_reads = err_idx + 1;
    end else if (noack_idx < len) begin
      e_err = 1'b1; e_timeout = 1'b1; e_reads = noack_idx;
    end
    if (e_err) begin
      e_icode = 4'd0; e_ifun = 4'd0; e_ra = 4'hF; e_rb = 4'hF;
      e_valc = 64'd0; e_valp = pc; e_valid = 1'b0;
    end else begin
      e_icode = ic;
      e_ifun  = prog[0][3:0];
      e_valid = (ic <= 4'hB);
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
        e_ra = prog[1][7:4]; e_rb = prog[1][3:0];
      end else begin
        e_ra = 4'hF; e_rb = 4'hF;
      end
      vo = (ic inside {4'h3, 4'h4, 4'h5}) ? 2 : (ic inside {4'h7, 4'h8}) ? 1 : 0;
      e_valc = 64'd0;
      if (vo != 0) for (int k = 0; k < 8; k++) e_valc[8*k +: 8] = prog[vo + k];
      e_valp = pc + 64'(len);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_req"}, 64'(imem_req), 64'd0);
    check({tag, "_addr"}, imem_addr, 64'd0);
    check({tag, "_icode"}, 64'(icode), 64'd0);
    check({tag, "_ifun"}, 64'(ifun), 64'd0);
    check({tag, "_rA"}, 64'(rA), 64'hF);
    check({tag, "_rB"}, 64'(rB), 64'hF);
    check({tag, "_valC"}, valC, 64'd0);
    check({tag, "_valP"}, valP, 64'd0);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_ierr"}, 64'(imem_error), 64'd0);
  endtask

  // Called at a negedge while idle; returns at a negedge while idle.
  task automatic run_fetch(input logic [63:0] pc, input int dmode, input int eidx,
                           input int nidx, input int fixed_lat, input bit hold,
                           input bit start_in_done);
    int n, exp_lat;
    base = pc; del_mode = dmode; err_idx = eidx; noack_idx = nidx;
    acks.delete(); req_cycles = 0; last_ack_at = 0;
    model(pc);
    start = 1'b1; pc_in = pc;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) pc_in = ~pc;
      if (n == (hold ? 2 : 1)) start = 1'b0;
    end while (!done && n < 300);
    check("done_seen", 64'(done), 64'd1);
    check("icode", 64'(icode), 64'(e_icode));
    check("ifun", 64'(ifun), 64'(e_ifun));
    check("rA", 64'(rA), 64'(e_ra));
    check("rB", 64'(rB), 64'(e_rb));
    check("valC", valC, e_valc);
    check("valP", valP, e_valp);
    check("instr_valid", 64'(instr_valid), 64'(e_valid));
    check("imem_error", 64'(imem_error), 64'(e_err));
    check("reads", 64'(acks.size()), 64'(e_reads));
    for (int i = 0; i < acks.size(); i++) check("addr", acks[i], pc + 64'(i));
    exp_lat = e_timeout ? last_ack_at + T + 1 : last_ack_at + 1;
    check("latency", 64'(n), 64'(exp_lat));
    if (fixed_lat > 0) check("latency_fixed", 64'(n), 64'(fixed_lat));
    $display("txn %0d pc=%h icode=%h valP=%h err=%0d lat=%0d", txn, pc, icode, valP,
             imem_error, n);
    txn++;
    if (start_in_done) begin
      start = 1'b1; pc_in = ~pc;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_values("rst0");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    load_bytes(80'h30F3EFCDAB8967452301);
    run_fetch(64'h100, 0, 99, 99, 11, 1'b0, 1'b0);
    check("irmovq_valC", valC, 64'h0123456789ABCDEF);
    load_bytes(80'h74000200000000000000);
    run_fetch(64'h40, 3, 99, 99, 37, 1'b1, 1'b0);
    check("jxx_valC", valC, 64'h200);
    load_bytes(80'h90000000000000000000);
    run_fetch(64'h500, 0, 99, 99, 2, 1'b0, 1'b1);
    load_bytes(80'h00000000000000000000);
    run_fetch(64'h600, 0, 99, 99, 2, 1'b0, 1'b0);
    load_bytes(80'hC5000000000000000000);
    run_fetch(64'h700, 0, 99, 99, 2, 1'b0, 1'b0);
    load_bytes(80'h40120800000000000000);
    run_fetch(64'h800, 0, 4, 99, 6, 1'b0, 1'b0);
    load_bytes(80'h60120000000000000000);
    run_fetch(64'h900, 0, 99, 1, 6, 1'b0, 1'b0);
    load_bytes(80'hA02F0000000000000000);
    run_fetch(64'hFFFFFFFFFFFFFFFF, -1, 99, 99, 0, 1'b0, 1'b0);
    check("wrap_valP", valP, 64'd1);

    for (int r = 0; r < 40; r++) begin
      int eidx, nidx;
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      eidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 99;
      nidx = (eidx == 99 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 99;
      run_fetch({$urandom, $urandom}, -1, eidx, nidx, 0, 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of the 5th byte of an mrmovq.
    load_bytes(80'h30F3EFCDAB8967452301);
    run_fetch(64'h300, 0, 99, 99, 11, 1'b0, 1'b0);
    load_bytes(80'h50371122334455667788);
    base = 64'h2000; del_mode = 0; err_idx = 99; noack_idx = 99;
    acks.delete();
    start = 1'b1; pc_in = 64'h2000;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (acks.size() < 4 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("pre_reset_acks", 64'(acks.size()), 64'd4);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    force_ack = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("late_ack_busy", 64'(busy), 64'd0);
    check("late_ack_icode", 64'(icode), 64'd0);
    check("late_ack_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    run_fetch(64'h2000, 0, 99, 99, 11, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
